// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode control and operands in, registered EX state,
// stall controls and event counters out.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0]        ALUOp, Branch;
  logic [DATA_W-1:0] ID_PC4, ID_Read1, ID_Read2, ID_Imm;
  logic [REG_AW-1:0] ID_Rs, ID_Rt, ID_Rd;
  logic              Flush;

  logic              Controller_Write, PC_Write, IF_ID_Write;
  logic              EX_RegDst, EX_MemRead, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite;
  logic [1:0]        EX_ALUOp, EX_Branch;
  logic [DATA_W-1:0] EX_PC4, EX_Read1, EX_Read2, EX_Imm;
  logic [REG_AW-1:0] EX_Rs, EX_Rt, EX_Rd;
  logic              EX_Valid;
  logic [CNT_W-1:0]  Stall_Count, Flush_Count;

  modport slave (
    input  RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, Branch,
    input  ID_PC4, ID_Read1, ID_Read2, ID_Imm, ID_Rs, ID_Rt, ID_Rd, Flush,
    output Controller_Write, PC_Write, IF_ID_Write,
    output EX_RegDst, EX_MemRead, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite,
    output EX_ALUOp, EX_Branch, EX_PC4, EX_Read1, EX_Read2, EX_Imm,
    output EX_Rs, EX_Rt, EX_Rd, EX_Valid, Stall_Count, Flush_Count
  );

  modport master (
    output RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, Branch,
    output ID_PC4, ID_Read1, ID_Read2, ID_Imm, ID_Rs, ID_Rt, ID_Rd, Flush,
    input  Controller_Write, PC_Write, IF_ID_Write,
    input  EX_RegDst, EX_MemRead, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite,
    input  EX_ALUOp, EX_Branch, EX_PC4, EX_Read1, EX_Read2, EX_Imm,
    input  EX_Rs, EX_Rt, EX_Rd, EX_Valid, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush
// insertion and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    id_ex_stage_if.slave    bus
);
    logic              hazard, stall_evt;
    logic [5:0]        ctrl_q;
    logic [1:0]        aluop_q, branch_q;
    logic              valid_q;
    logic [DATA_W-1:0] pc4_q, rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [CNT_W-1:0]  stall_q, flush_q;

    // Gated by rst_n so the stall controls read "run" while reset is held.
    always_comb begin
        hazard    = rst_n & valid_q & ctrl_q[4] & (rt_q != '0) &
                    ((rt_q == bus.ID_Rs) | (rt_q == bus.ID_Rt));
        stall_evt = hazard & ~bus.Flush;
        bus.Controller_Write = hazard;
        bus.PC_Write         = ~hazard;
        bus.IF_ID_Write      = ~hazard;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            aluop_q  <= '0;
            branch_q <= '0;
            valid_q  <= 1'b0;
        end else if (bus.Flush || hazard) begin
            ctrl_q   <= '0;
            aluop_q  <= '0;
            branch_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            ctrl_q   <= {bus.RegDst, bus.MemRead, bus.MemtoReg,
                         bus.MemWrite, bus.ALUSrc, bus.RegWrite};
            aluop_q  <= bus.ALUOp;
            branch_q <= bus.Branch;
            valid_q  <= 1'b1;
        end
    end

    // Operands only move with a real instruction; bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else if (!bus.Flush && !hazard) begin
            pc4_q <= bus.ID_PC4;
            rd1_q <= bus.ID_Read1;
            rd2_q <= bus.ID_Read2;
            imm_q <= bus.ID_Imm;
            rs_q  <= bus.ID_Rs;
            rt_q  <= bus.ID_Rt;
            rd_q  <= bus.ID_Rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (bus.Flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    always_comb begin
        {bus.EX_RegDst, bus.EX_MemRead, bus.EX_MemtoReg,
         bus.EX_MemWrite, bus.EX_ALUSrc, bus.EX_RegWrite} = ctrl_q;
        bus.EX_ALUOp    = aluop_q;
        bus.EX_Branch   = branch_q;
        bus.EX_Valid    = valid_q;
        bus.EX_PC4      = pc4_q;
        bus.EX_Read1    = rd1_q;
        bus.EX_Read2    = rd2_q;
        bus.EX_Imm      = imm_q;
        bus.EX_Rs       = rs_q;
        bus.EX_Rt       = rt_q;
        bus.EX_Rd       = rd_q;
        bus.Stall_Count = stall_q;
        bus.Flush_Count = flush_q;
    end
endmodule
